// File: rtl/hamming_encoder_serial.sv
// hamming_encoder_serial: serial Hamming(21,16) even-parity encoder, one codeword position per clock
module hamming_encoder_serial (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] codeword,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
    state_t      state, state_n;
    logic [4:0]  pos, pos_n, par, par_n, par_upd, idx;
    logic [20:0] cw, cw_n;
    logic [31:0] cw_ext;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pos   <= '0;
            par   <= '0;
            cw    <= '0;
        end else begin
            state <= state_n;
            pos   <= pos_n;
            par   <= par_n;
            cw    <= cw_n;
        end
    end
    // Every parity bit whose index bit is set in pos picks up the current position's bit.
    always_comb begin
        state_n = state;
        pos_n   = pos;
        par_n   = par;
        cw_n    = cw;
        idx     = pos - 5'd1;
        cw_ext  = {11'b0, cw};
        par_upd = par ^ (pos & {5{cw_ext[idx]}});
        case (state)
            IDLE: if (in_valid) begin
                cw_n    = {data[15:11], 1'b0, data[10:4], 1'b0, data[3:1], 1'b0, data[0], 2'b00};
                par_n   = '0;
                pos_n   = 5'd1;
                state_n = CALC;
            end
            CALC: begin
                par_n = par_upd;
                if (pos == 5'd21) begin
                    cw_n[0]  = par_upd[0];
                    cw_n[1]  = par_upd[1];
                    cw_n[3]  = par_upd[2];
                    cw_n[7]  = par_upd[3];
                    cw_n[15] = par_upd[4];
                    state_n  = OUT;
                end else begin
                    pos_n = pos + 5'd1;
                end
            end
            OUT: state_n = out_ready ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);
    assign codeword  = cw;
endmodule

// File: tb/tb_hamming_encoder_serial.sv
// tb_hamming_encoder_serial: table vectors, scoreboard with reference encoder/decoder, corner sequences
module tb_hamming_encoder_serial;
    logic        clk = 0, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] data;
    logic [20:0] codeword;
    int          checks = 0, failures = 0;

    typedef struct { logic [15:0] d; logic [20:0] c; } vec_t;
    vec_t vecs[6];
    vec_t sb[$];
    vec_t e;

    hamming_encoder_serial dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] enc(input logic [15:0] d);
        logic [20:0] c = '0;
        int j = 0;
        for (int i = 1; i <= 21; i++)
            if ((i & (i - 1)) != 0) begin c[i-1] = d[j]; j++; end
        for (int k = 0; k < 5; k++) begin
            logic p = 1'b0;
            for (int i = 1; i <= 21; i++)
                if ((i & (1 << k)) != 0) p ^= c[i-1];
            c[(1 << k) - 1] = p;
        end
        return c;
    endfunction

    function automatic int syn(input logic [20:0] c);
        int s = 0;
        for (int i = 1; i <= 21; i++) if (c[i-1]) s ^= i;
        return s;
    endfunction

    function automatic logic [15:0] dec(input logic [20:0] cw);
        logic [20:0] c = cw;
        logic [15:0] d = '0;
        int s, j = 0;
        s = syn(c);
        if (s >= 1 && s <= 21) c[s-1] = ~c[s-1];
        for (int i = 1; i <= 21; i++)
            if ((i & (i - 1)) != 0) begin d[j] = c[i-1]; j++; end
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        in_valid = 1; data = d;
        while (!in_ready && n < 200) begin step(); n++; end
        if (n >= 200) chk("in_ready_timeout", {31'b0, in_ready}, 1);
        step();
        in_valid = 0; data = 16'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin step(); lat++; end
    endtask

    task automatic drain(input bit rnd);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            step(); n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        out_ready = 1;
    endtask

    // Scoreboard: push on accept, pop and fully check on output handshake.
    always @(negedge clk) begin : mon
        int b;
        if (in_valid && in_ready) sb.push_back('{data, enc(data)});
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_out: got codeword %h with nothing expected", codeword);
            end else begin
                e = sb.pop_front();
                b = $urandom_range(0, 20);
                chk("sb_codeword", {11'b0, codeword}, {11'b0, e.c});
                chk("sb_syndrome", syn(codeword), 0);
                chk("sb_decoded", {16'b0, dec(codeword)}, {16'b0, e.d});
                chk("sb_corrected", {16'b0, dec(codeword ^ (21'd1 << b))}, {16'b0, e.d});
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, cnt;
        int acc[$];
        vecs[0] = '{16'h0000, 21'h000000};
        vecs[1] = '{16'h0001, 21'h000007};
        vecs[2] = '{16'h8000, 21'h108009};
        vecs[3] = '{16'hFFFF, 21'h1FFFFE};
        vecs[4] = '{16'h0002, 21'h000019};
        vecs[5] = '{16'h0010, 21'h000181};
        rst = 1; in_valid = 0; out_ready = 1; data = '0;
        repeat (3) step();
        chk("in_ready_in_rst", {31'b0, in_ready}, 0);
        chk("out_valid_rst", {31'b0, out_valid}, 0);
        chk("codeword_rst", {11'b0, codeword}, 0);
        chk("busy_rst", {31'b0, busy}, 0);
        rst = 0; #1;
        chk("in_ready_after_rst", {31'b0, in_ready}, 1);
        step();

        foreach (vecs[i]) begin
            send(vecs[i].d);
            chk("busy_calc", {31'b0, busy}, 1);
            wait_out(lat);
            chk("latency", lat, 22);
            chk("vec_codeword", {11'b0, codeword}, {11'b0, vecs[i].c});
            step();
            chk("vec_out_valid_drop", {31'b0, out_valid}, 0);
            chk("vec_in_ready_back", {31'b0, in_ready}, 1);
            chk("vec_codeword_hold", {11'b0, codeword}, {11'b0, vecs[i].c});
        end

        out_ready = 0;
        send(16'hFFFF);
        wait_out(lat);
        chk("bp_latency", lat, 22);
        repeat (10) begin
            chk("bp_out_valid", {31'b0, out_valid}, 1);
            chk("bp_codeword", {11'b0, codeword}, 32'h1FFFFE);
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            step();
        end
        out_ready = 1;
        step();
        chk("bp_out_valid_drop", {31'b0, out_valid}, 0);
        chk("bp_in_ready_back", {31'b0, in_ready}, 1);
        drain(0);

        send(16'h1234);
        repeat (9) step();
        rst = 1;
        step();
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_codeword", {11'b0, codeword}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 0);
        rst = 0; #1;
        chk("mid_rst_in_ready_after", {31'b0, in_ready}, 1);
        sb.delete();
        cnt = 0;
        repeat (30) begin cnt += int'(out_valid); step(); end
        chk("no_out_after_rst", cnt, 0);
        send(16'hBEEF);
        drain(0);

        in_valid = 1;
        for (int c = 0; c < 80; c++) begin
            data = 16'h0100 + 16'(c);
            if (in_ready) acc.push_back(c);
            step();
        end
        in_valid = 0;
        chk("b2b_accepts", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) chk("b2b_interval", acc[i] - acc[i-1], 23);
        drain(0);

        repeat (1000) begin
            send(16'($urandom));
            drain(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
